// File: rtl/dispatch_buffer.sv
// Dispatch buffer: circular FIFO between register rename and issue.
// Accepts up to three renamed uops per cycle (compacted on write) and
// presents the oldest three buffered uops to the issue stage.

`ifndef UOP_VALID_B
`define UOP_VALID_B 63
`endif

module dispatch_buffer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned UOP_W   = 64,
  parameter int unsigned VALID_B = `UOP_VALID_B
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [2:0][UOP_W-1:0]        uops_i,
  output logic                         enq_ready_o,
  input  logic [1:0]                   deq_count_i,
  output logic [2:0][UOP_W-1:0]        uops_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Storage is deliberately not reset; occupancy gating zeroes the outputs.
  logic [UOP_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic [2:0]          w_valid;
  logic                w_enq_ok;
  logic [2:0][1:0]     w_off;
  logic [2:0][PW-1:0]  w_waddr;
  logic [2:0]          w_we;
  logic [1:0]          w_n_enq;
  logic [1:0]          w_n_deq;

  // Ready depends only on registered occupancy so upstream never sees a deq path.
  assign enq_ready_o = (r_count <= CW'(DEPTH - 3));
  assign count_o     = r_count;

  // Enqueue compaction: each valid slot lands after the valid slots older than it.
  always_comb begin
    w_enq_ok = enq_ready_o & ~flush_i & ~rst;
    for (int k = 0; k < 3; k++) begin
      w_valid[k] = uops_i[k][VALID_B];
    end
    w_off[0] = 2'd0;
    w_off[1] = {1'b0, w_valid[0]};
    w_off[2] = {1'b0, w_valid[0]} + {1'b0, w_valid[1]};
    for (int k = 0; k < 3; k++) begin
      w_waddr[k] = r_tail + PW'(w_off[k]);
      w_we[k]    = w_enq_ok & w_valid[k];
    end
    w_n_enq = w_enq_ok ? (w_off[2] + {1'b0, w_valid[2]}) : 2'd0;
  end

  // Dequeue is clipped to current occupancy.
  always_comb begin
    w_n_deq = (CW'(deq_count_i) > r_count) ? r_count[1:0] : deq_count_i;
  end

  // Head window: slot k shows entry head+k only while that entry is occupied.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      if (CW'(k) < r_count) begin
        uops_o[k] = r_mem[r_head + PW'(k)];
      end else begin
        uops_o[k] = '0;
      end
    end
  end

  // Entry storage write; up to three distinct addresses per cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (w_we[k]) begin
        r_mem[w_waddr[k]] <= uops_i[k];
      end
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats enq/deq.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_deq);
      r_tail  <= r_tail + PW'(w_n_enq);
      r_count <= r_count + CW'(w_n_enq) - CW'(w_n_deq);
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed self-checking bench for dispatch_buffer (default parameters).

module tb_dispatch_buffer;

  logic             clk;
  logic             rst;
  logic             flush_i;
  logic [2:0][63:0] uops_i;
  logic             enq_ready_o;
  logic [1:0]       deq_count_i;
  logic [2:0][63:0] uops_o;
  logic [4:0]       count_o;

  int n_cmp;
  int n_err;

  dispatch_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .uops_i      (uops_i),
    .enq_ready_o (enq_ready_o),
    .deq_count_i (deq_count_i),
    .uops_o      (uops_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Uop word: valid in bit 63, fixed filler, tag in the low 32 bits.
  function automatic logic [63:0] mk(input int t, input bit v);
    mk = {v, 15'h1234, 16'hBEEF, 32'(t)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    flush_i     = 1'b0;
    deq_count_i = 2'd3;
    uops_i      = {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    step();
    uops_i      = {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    step();
    rst         = 1'b0;
    deq_count_i = 2'd0;
    uops_i      = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (count_o !== 5'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", count_o);
    end
    n_cmp++;
    if (uops_o !== '0) begin
      n_err++; $display("FAIL reset_uops: got %h want 0", uops_o);
    end
    n_cmp++;
    if (enq_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b want 1", enq_ready_o);
    end
  endtask

  task automatic test_compaction();
    logic [63:0] a, b, c;
    do_reset();
    a = mk(32'hA, 1'b1);
    b = mk(32'hB, 1'b0);
    c = mk(32'hC, 1'b1);
    uops_i[0] = a; uops_i[1] = b; uops_i[2] = c;
    step();
    uops_i = '0;
    n_cmp++;
    if (count_o !== 5'd2) begin
      n_err++; $display("FAIL compact_count: got %0d want 2", count_o);
    end
    n_cmp++;
    if (uops_o[0] !== a) begin
      n_err++; $display("FAIL compact_o0: got %h want %h", uops_o[0], a);
    end
    n_cmp++;
    if (uops_o[1] !== c) begin
      n_err++; $display("FAIL compact_o1: got %h want %h", uops_o[1], c);
    end
    n_cmp++;
    if (uops_o[2] !== 64'd0) begin
      n_err++; $display("FAIL compact_o2: got %h want 0", uops_o[2]);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 3; k++) uops_i[k] = mk(100 + g * 3 + k, 1'b1);
      step();
    end
    uops_i = '0;
    n_cmp++;
    if (count_o !== 5'd15) begin
      n_err++; $display("FAIL full_count: got %0d want 15", count_o);
    end
    n_cmp++;
    if (enq_ready_o !== 1'b0) begin
      n_err++; $display("FAIL full_ready: got %b want 0", enq_ready_o);
    end
    // Sixth group offered while not ready must be dropped.
    for (int k = 0; k < 3; k++) uops_i[k] = mk(900 + k, 1'b1);
    step();
    uops_i = '0;
    n_cmp++;
    if (count_o !== 5'd15) begin
      n_err++; $display("FAIL full_hold_count: got %0d want 15", count_o);
    end
    // Drain: order must be tags 100..114, never 900..902.
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (uops_o[k] !== mk(100 + g * 3 + k, 1'b1)) begin
          n_err++;
          $display("FAIL full_drain[%0d][%0d]: got %h want %h", g, k, uops_o[k],
                   mk(100 + g * 3 + k, 1'b1));
        end
      end
      deq_count_i = 2'd3;
      step();
    end
    deq_count_i = 2'd0;
    n_cmp++;
    if (count_o !== 5'd0 || uops_o !== '0) begin
      n_err++; $display("FAIL full_drained: got count %0d uops %h want 0", count_o, uops_o);
    end
  endtask

  task automatic test_wrap();
    int m_cnt, tx, rx, cyc, d, nd, ne, max_cnt;
    m_cnt = 0; tx = 0; rx = 0; cyc = 0; max_cnt = 0;
    do_reset();
    while (rx < 40 && cyc < 300) begin
      n_cmp++;
      if (count_o !== 5'(m_cnt)) begin
        n_err++; $display("FAIL wrap_count c%0d: got %0d want %0d", cyc, count_o, m_cnt);
      end
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      d  = 3 - (cyc % 3);
      nd = (d < m_cnt) ? d : m_cnt;
      for (int k = 0; k < nd; k++) begin
        n_cmp++;
        if (uops_o[k] !== mk(1000 + rx + k, 1'b1)) begin
          n_err++;
          $display("FAIL wrap_data tag%0d: got %h want %h", rx + k, uops_o[k],
                   mk(1000 + rx + k, 1'b1));
        end
      end
      deq_count_i = 2'(d);
      uops_i      = '0;
      ne          = 0;
      if (m_cnt <= 13) begin
        for (int k = 0; k < 3; k++) begin
          if (tx + k < 40) begin
            uops_i[k] = mk(1000 + tx + k, 1'b1);
            ne++;
          end
        end
      end
      step();
      tx    += ne;
      rx    += nd;
      m_cnt += ne - nd;
      cyc++;
    end
    deq_count_i = 2'd0;
    uops_i      = '0;
    n_cmp++;
    if (rx != 40 || tx != 40) begin
      n_err++; $display("FAIL wrap_done: got rx %0d tx %0d want 40", rx, tx);
    end
    n_cmp++;
    if (max_cnt > 16 || count_o !== 5'd0) begin
      n_err++; $display("FAIL wrap_bound: got max %0d final %0d want <=16 and 0", max_cnt, count_o);
    end
  endtask

  task automatic test_underflow();
    logic [63:0] x, y, z;
    do_reset();
    x = mk(32'h51, 1'b1);
    y = mk(32'h52, 1'b1);
    z = mk(32'h53, 1'b1);
    uops_i = '0; uops_i[1] = x;
    step();
    n_cmp++;
    if (count_o !== 5'd1 || uops_o[0] !== x) begin
      n_err++; $display("FAIL uflow_pre: got %0d %h want 1 %h", count_o, uops_o[0], x);
    end
    uops_i = '0; uops_i[0] = y; uops_i[2] = z;
    deq_count_i = 2'd3;
    step();
    uops_i = '0; deq_count_i = 2'd0;
    n_cmp++;
    if (count_o !== 5'd2) begin
      n_err++; $display("FAIL uflow_count: got %0d want 2", count_o);
    end
    n_cmp++;
    if (uops_o[0] !== y || uops_o[1] !== z || uops_o[2] !== 64'd0) begin
      n_err++; $display("FAIL uflow_data: got %h want %h_%h_0", uops_o, z, y);
    end
  endtask

  task automatic test_flush();
    logic [63:0] w;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      uops_i = '0;
      for (int k = 0; k < 3; k++) if (g < 3 || k == 0) uops_i[k] = mk(200 + g * 3 + k, 1'b1);
      step();
    end
    uops_i = '0;
    n_cmp++;
    if (count_o !== 5'd10) begin
      n_err++; $display("FAIL flush_pre: got %0d want 10", count_o);
    end
    flush_i = 1'b1;
    deq_count_i = 2'd2;
    for (int k = 0; k < 3; k++) uops_i[k] = mk(300 + k, 1'b1);
    step();
    flush_i = 1'b0; deq_count_i = 2'd0; uops_i = '0;
    n_cmp++;
    if (count_o !== 5'd0) begin
      n_err++; $display("FAIL flush_count: got %0d want 0", count_o);
    end
    n_cmp++;
    if (uops_o !== '0 || enq_ready_o !== 1'b1) begin
      n_err++; $display("FAIL flush_out: got %h rdy %b want 0 rdy 1", uops_o, enq_ready_o);
    end
    w = mk(32'h77, 1'b1);
    uops_i[2] = w;
    step();
    uops_i = '0;
    n_cmp++;
    if (count_o !== 5'd1 || uops_o[0] !== w) begin
      n_err++; $display("FAIL flush_after: got %0d %h want 1 %h", count_o, uops_o[0], w);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; flush_i = 1'b0; deq_count_i = 2'd0; uops_i = '0;
    test_reset();
    test_compaction();
    test_full();
    test_underflow();
    test_flush();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
